// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port feeder: size defaults,
// index-width derivation and the loader FSM state type.
package regfile_pkg;

  localparam int unsigned NDefault = 8;
  localparam int unsigned RDefault = 32;

  // Register index width; a single-register file still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/regfile_burst_loader.sv
// Burst loader: takes (base, count) then streams words through a FIFO into the
// register-file write port, one write per cycle with a wrapping register index.
module regfile_burst_loader
  import regfile_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned R  = RDefault,
  parameter int unsigned RR = idx_width(R),
  parameter int unsigned D  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RR-1:0] base_id,
  input  logic [RR:0]   count,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  rf_data,
  output logic [RR-1:0] rf_id_w,
  output logic          rf_wr,
  output logic          busy,
  output logic          done
);

  localparam logic [RR:0]   CntOne = (RR+1)'(1);
  localparam logic [RR:0]   CntMax = (RR+1)'(R);
  localparam logic [RR-1:0] IdLast = RR'(R - 1);

  state_e        state_q, state_d;
  logic [RR-1:0] wr_id_q, wr_id_d;
  logic [RR:0]   to_accept_q, to_accept_d;
  logic [RR:0]   to_write_q, to_write_d;
  logic [N-1:0]  rf_data_q, rf_data_d;
  logic [RR-1:0] rf_id_w_q, rf_id_w_d;
  logic          rf_wr_q, rf_wr_d;

  logic [RR:0]   count_clamped;
  logic          fifo_full, fifo_empty;
  logic [N-1:0]  fifo_dout;
  logic          push, pop;

  assign count_clamped = (count > CntMax) ? CntMax : count;

  // in_ready depends only on registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready = (state_q == StLoad) && !fifo_full && (to_accept_q != '0);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StLoad) && !fifo_empty && (to_write_q != '0);

  sync_fifo #(
    .W     (N),
    .DEPTH (D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    wr_id_d     = wr_id_q;
    to_accept_d = to_accept_q;
    to_write_d  = to_write_q;
    rf_data_d   = rf_data_q;
    rf_id_w_d   = rf_id_w_q;
    rf_wr_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (count_clamped != '0) begin
            state_d     = StLoad;
            wr_id_d     = base_id;
            to_accept_d = count_clamped;
            to_write_d  = count_clamped;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (push) to_accept_d = to_accept_q - CntOne;
        if (pop) begin
          rf_data_d  = fifo_dout;
          rf_id_w_d  = wr_id_q;
          rf_wr_d    = 1'b1;
          wr_id_d    = (wr_id_q == IdLast) ? '0 : wr_id_q + RR'(1);
          to_write_d = to_write_q - CntOne;
          if (to_write_q == CntOne) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_id_q     <= '0;
      to_accept_q <= '0;
      to_write_q  <= '0;
      rf_data_q   <= '0;
      rf_id_w_q   <= '0;
      rf_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_id_q     <= wr_id_d;
      to_accept_q <= to_accept_d;
      to_write_q  <= to_write_d;
      rf_data_q   <= rf_data_d;
      rf_id_w_q   <= rf_id_w_d;
      rf_wr_q     <= rf_wr_d;
    end
  end

  assign rf_data = rf_data_q;
  assign rf_id_w = rf_id_w_q;
  assign rf_wr   = rf_wr_q;
  assign busy    = (state_q == StLoad);
  assign done    = (state_q == StDone);

endmodule

// File: doc/regfile_burst_loader.md
Name: regfile_burst_loader

Overview:
- Upstream write-port feeder for the NxR register file (regfile32x8 instance in the core).
- Accepts a burst command (base register, word count), then takes data words over a valid/ready stream.
- Buffers the words in a small FIFO and drives the register-file write port (data, write id, wr), one write per cycle.
- Register index auto-increments and wraps modulo R.

Parameters:
- N, 8, data word width (matches register file N)
- R, 32, number of registers (matches register file R)
- RR, $clog2(R), register index width
- D, 4, input FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset: state clears on a rising clk edge while rst==0
- start  in  1  burst request pulse; sampled only in IDLE
- base_id  in  RR  first register index of the burst
- count  in  RR+1  number of words, 0..R; values >R clamp to R
- in_valid  in  1  input word valid
- in_data  in  N  input word
- in_ready  out  1  block accepts in_data this cycle
- rf_data  out  N  to register file data_in
- rf_id_w  out  RR  to register file reg_id_w
- rf_wr  out  1  to register file wr; one-cycle pulse per word
- busy  out  1  burst in progress (LOAD state)
- done  out  1  one-cycle pulse when the last write has been issued

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; FIFO flushed.
  - in_ready=0, rf_wr=0, rf_data=0, rf_id_w=0, busy=0, done=0.
  - Internal counters cleared.
  - Reset mid-burst aborts the burst with no further writes and no done pulse.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD:
  - Transition on the edge where start==1 and clamped count!=0.
  - That edge latches wr_id=base_id, to_accept=count, to_write=count.
- IDLE with start==1 and count==0 -> DONE. No writes are issued.
- start is ignored in LOAD and DONE.
- LOAD, input side:
  - in_ready = (FIFO not full) && (to_accept!=0). in_ready is a combinational function of registered state only.
  - A handshake is in_valid&&in_ready at an edge. It pushes the word and decrements to_accept.
  - Words offered after to_accept reaches 0 are never accepted.
- LOAD, write side:
  - On each edge where the FIFO is non-empty and to_write!=0:
    - pop the head word;
    - register rf_data=word, rf_id_w=wr_id, rf_wr=1;
    - wr_id advances (R-1 wraps to 0);
    - to_write decrements.
  - Otherwise rf_wr=0 next cycle.
  - rf_data and rf_id_w hold their last value when rf_wr=0.
- Latency:
  - A word handshaked at edge E is presented on rf_* (rf_wr=1) after edge E+1, when the FIFO was empty.
  - The register file captures that word at edge E+2.
  - Sustained throughput is 1 word/cycle.
- Simultaneous push and pop in the same cycle is legal at any occupancy. When full, a pop frees the slot for the following cycle, not the same cycle (in_ready comes from registered state).
- LOAD -> DONE on the edge that issues the final write (to_write 1 -> 0).
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- busy=1 exactly while in LOAD.
- The write-side pop is not gated by in_valid. Upstream stalls only insert rf_wr=0 bubbles.
- Width rules:
  - count is clamped to R before latching.
  - to_accept and to_write are RR+1 bits.
  - Wrap uses compare-with-R-1, not truncation, so non-power-of-2 R is correct.

Decomposition:
- Shared package regfile_pkg:
  - N/R defaults and RR derivation;
  - FSM state enum (IDLE, LOAD, DONE).
- One sub-module: sync_fifo (parameters W=N, DEPTH=D).
  - Ports: push, pop, din, dout, full, empty; same clk and rst.
  - Show-ahead (first-word-fall-through) dout.

Test Plan:
- Reset mid-burst: start base_id=0 count=8, drive rst=0 after the 3rd rf_wr -> all outputs 0 on the next edge, no further rf_wr, no done; a new burst then runs normally.
- Full burst: start base_id=0, count=32, 32 words streamed with in_valid always high -> rf_wr=1 for 32 consecutive cycles, ids 0..31, data in order, done pulses once; reading the regfile back (ids 0..31) returns the words.
- Wrap: base_id=30, count=4, data 0xA1..0xA4 -> writes to ids 30,31,0,1 in that order; busy high for the whole burst.
- Backpressure: count=8, in_valid high for 8 cycles but the writes cannot outpace the FIFO; additionally hold a 9th word on in_valid -> in_ready drops after the 8th handshake, the 9th word is never written, exactly 8 rf_wr pulses.
- Bubbles and count edge cases:
  - count=5 with in_valid toggling 1,0,1,0,... -> rf_wr shows matching bubbles, first rf_wr 1 cycle after the first handshake, done after the 5th write.
  - count=0 -> done pulse one cycle after start, no rf_wr.
  - count=40 -> clamped, exactly 32 writes.
- start while busy: assert start with base_id=5 during an active burst -> ignored; ids continue from the original base.
